// File: rtl/adc_spi_capture.sv
// adc_spi_capture: serial-ADC front end. Clocks one frame out of an
// AD7476-class SPI ADC (leading zeros, then data MSB first), checks the
// leading zeros and holds the extended code on 'sample'.
// Build option: define ADC_OFFSET_BIN_EN to treat the code as offset-binary
// and sign-extend (code - 2^(ADC_BITS-1)); otherwise the code is zero-extended.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | cs_n high, waiting for ena_adc
// S_SETUP | cs_n low, CLK_DIV cycles of chip-select setup
// S_SHIFT | sclk toggling, one frame bit per sclk period
// S_DONE  | one cycle: publish sample or flag frame error
// S_QUIET | cs_n high for QUIET_CYC cycles before the next request
//
// Outputs are registered from the current state, so every output lags the
// state register by one clock.
module adc_spi_capture #(
  parameter int CLK_DIV    = 4,
  parameter int QUIET_CYC  = 8,
  parameter int ADC_BITS   = 12,
  parameter int LEAD_ZEROS = 4,
  parameter int OUT_W      = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena_adc,
  input  logic             adc_sdata,
  output logic             adc_cs_n,
  output logic             adc_sclk,
  output logic [OUT_W-1:0] sample,
  output logic             sample_valid,
  output logic             frame_err,
  output logic             busy
);

  localparam int FRAME_BITS = LEAD_ZEROS + ADC_BITS;
  localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int QUIET_W    = (QUIET_CYC > 1) ? $clog2(QUIET_CYC) : 1;
  localparam int BIT_W      = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [QUIET_W-1:0] QUIET_LAST = QUIET_W'(QUIET_CYC - 1);
  localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(FRAME_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_DONE,
    S_QUIET
  } state_e;

  state_e                state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic                  phase_q, phase_d;   // 0: sclk low half, 1: sclk high half
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [QUIET_W-1:0]    quiet_q, quiet_d;
  logic                  sdata_q;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic                  cs_n_q, cs_n_d;
  logic                  sclk_q, sclk_d;
  logic [OUT_W-1:0]      sample_q, sample_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;

  logic                  shift_en;
  logic                  lead_ok;
  logic [ADC_BITS-1:0]   code;
  logic [OUT_W-1:0]      code_ext;

  // State and counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      phase_q <= 1'b0;
      bit_q   <= '0;
      quiet_q <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      quiet_q <= quiet_d;
    end
  end

  // Next-state logic: down-counters reload on terminal count
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    quiet_d = quiet_q;
    case (state_q)
      S_IDLE: begin
        if (ena_adc) begin
          state_d = S_SETUP;
          div_d   = DIV_LAST;
        end
      end
      S_SETUP: begin
        if (div_q == '0) begin
          state_d = S_SHIFT;
          div_d   = DIV_LAST;
          phase_d = 1'b0;
          bit_d   = '0;
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      S_SHIFT: begin
        if (div_q == '0) begin
          div_d = DIV_LAST;
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (bit_q == BIT_LAST) begin
              state_d = S_DONE;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_QUIET;
        quiet_d = QUIET_LAST;
      end
      S_QUIET: begin
        if (quiet_q == '0) begin
          state_d = S_IDLE;
        end else begin
          quiet_d = quiet_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Frame decode: capture on the first cycle of the sclk-high half, which is
  // the same clock on which the registered sclk output rises.
  always_comb begin
    shift_en = (state_q == S_SHIFT) && phase_q && (div_q == DIV_LAST);
    shreg_d  = shift_en ? {shreg_q[FRAME_BITS-2:0], sdata_q} : shreg_q;
    lead_ok  = (shreg_q[FRAME_BITS-1 -: LEAD_ZEROS] == '0);
    code     = shreg_q[ADC_BITS-1:0];
`ifdef ADC_OFFSET_BIN_EN
    // Inverting the MSB subtracts mid-scale; then sign-extend.
    code_ext = {{(OUT_W-ADC_BITS){~code[ADC_BITS-1]}}, ~code[ADC_BITS-1], code[ADC_BITS-2:0]};
`else
    code_ext = {{(OUT_W-ADC_BITS){1'b0}}, code};
`endif
  end

  // Output next values, derived from the current state
  always_comb begin
    cs_n_d   = !((state_q == S_SETUP) || (state_q == S_SHIFT));
    sclk_d   = !((state_q == S_SHIFT) && !phase_q);
    valid_d  = (state_q == S_DONE) && lead_ok;
    err_d    = (state_q == S_DONE) && !lead_ok;
    sample_d = valid_d ? code_ext : sample_q;
    busy_d   = (state_q != S_IDLE);
  end

  // Input synchroniser, shift register and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sdata_q  <= 1'b0;
      shreg_q  <= '0;
      cs_n_q   <= 1'b1;
      sclk_q   <= 1'b1;
      sample_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      sdata_q  <= adc_sdata;
      shreg_q  <= shreg_d;
      cs_n_q   <= cs_n_d;
      sclk_q   <= sclk_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  assign adc_cs_n     = cs_n_q;
  assign adc_sclk     = sclk_q;
  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign frame_err    = err_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_adc_spi_capture.sv
// Bench for adc_spi_capture: channel 0 runs CLK_DIV=4, channel 1 CLK_DIV=1.
// Stimulus pushes expected results into per-channel queues; a monitor pops
// and compares whenever sample_valid or frame_err is seen.
module tb_adc_spi_capture;

  localparam longint PER   = 10;
  localparam longint HALF  = 5;
  localparam int     QCYC  = 8;
  localparam int     LAT0  = 33 * 4 + 1;
  localparam int     LAT1  = 33 * 1 + 1;
  localparam int     FULL0 = 33 * 4 + QCYC + 2;

  typedef struct {
    bit          err;
    logic [17:0] smp;
    longint      t0;    // start edge time, or -1 when not checked
    int          gap;   // cycles since previous event on channel, 0 = unchecked
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  ena;
  logic [1:0]  sdata;
  logic [1:0]  cs_n, sclk, valid, ferr, busy;
  logic [17:0] samp [2];

  exp_t        exp0[$], exp1[$];
  logic [15:0] frames0[$], frames1[$];

  int          n_chk, n_err;

  // ADC model state
  logic        prev_cs [2];
  logic        prev_sclk [2];
  int          idx [2];
  logic [15:0] cur [2];
  int          rises [2];
  int          rises_done [2];
  int          falls [2];
  longint      fall_t [2];
  longint      last_rise [2];
  longint      rise_per [2];
  longint      last_evt [2];

  always #(HALF) clk = ~clk;

  adc_spi_capture #(.CLK_DIV(4), .QUIET_CYC(QCYC)) u_dut0 (
    .clk(clk), .rst(rst), .ena_adc(ena[0]), .adc_sdata(sdata[0]),
    .adc_cs_n(cs_n[0]), .adc_sclk(sclk[0]), .sample(samp[0]),
    .sample_valid(valid[0]), .frame_err(ferr[0]), .busy(busy[0])
  );

  adc_spi_capture #(.CLK_DIV(1), .QUIET_CYC(QCYC)) u_dut1 (
    .clk(clk), .rst(rst), .ena_adc(ena[1]), .adc_sdata(sdata[1]),
    .adc_cs_n(cs_n[1]), .adc_sclk(sclk[1]), .sample(samp[1]),
    .sample_valid(valid[1]), .frame_err(ferr[1]), .busy(busy[1])
  );

  function automatic logic [17:0] ext(input logic [11:0] c);
`ifdef ADC_OFFSET_BIN_EN
    int v;
    v = int'(c) - 2048;
    return v[17:0];
`else
    return {6'd0, c};
`endif
  endfunction

  function automatic void push_exp(input int g, input bit err, input logic [17:0] s,
                                   input longint t0, input int gap);
    exp_t e;
    e.err = err; e.smp = s; e.t0 = t0; e.gap = gap;
    if (g == 0) exp0.push_back(e);
    else        exp1.push_back(e);
  endfunction

  function automatic logic [15:0] pop_frame(input int g);
    if (g == 0) return (frames0.size() > 0) ? frames0.pop_front() : 16'h0000;
    else        return (frames1.size() > 0) ? frames1.pop_front() : 16'h0000;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic start_pulse(input int g, output longint t0);
    @(posedge clk); #1 ena[g] = 1'b1;
    @(posedge clk); t0 = $time; #1 ena[g] = 1'b0;
  endtask

  task automatic start_hold(input int g, output longint t0);
    @(posedge clk); #1 ena[g] = 1'b1;
    @(posedge clk); t0 = $time; #1;
  endtask

  initial begin
    longint t0;
    int     f0;
    n_chk = 0; n_err = 0;
    rst = 1'b0; ena = 2'b00; sdata = 2'b00;
    for (int g = 0; g < 2; g++) begin
      prev_cs[g] = 1'b1; prev_sclk[g] = 1'b1; idx[g] = 0; cur[g] = '0;
      rises[g] = 0; rises_done[g] = 0; falls[g] = 0; fall_t[g] = 0;
      last_rise[g] = 0; rise_per[g] = 0; last_evt[g] = 0;
    end

    fork
      // ADC model: presents the next bit after each sclk rise it observes
      forever begin
        @(posedge clk); #1;
        for (int g = 0; g < 2; g++) begin
          if (prev_cs[g] && !cs_n[g]) begin
            falls[g]++;
            fall_t[g] = $time - 1;
            cur[g] = pop_frame(g);
            idx[g] = 15;
            rises[g] = 0;
            sdata[g] = cur[g][15];
          end else if (!prev_cs[g] && cs_n[g]) begin
            rises_done[g] = rises[g];
          end
          if (!cs_n[g] && !prev_sclk[g] && sclk[g]) begin
            rises[g]++;
            rise_per[g] = $time - last_rise[g];
            last_rise[g] = $time;
            if (idx[g] > 0) idx[g]--;
            sdata[g] = cur[g][idx[g]];
          end
          prev_cs[g] = cs_n[g];
          prev_sclk[g] = sclk[g];
        end
      end
      // Monitor / scoreboard
      forever begin
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
          if (valid[g] || ferr[g]) begin
            exp_t   e;
            longint edge_t;
            int     qs;
            edge_t = $time - HALF;
            qs = (g == 0) ? exp0.size() : exp1.size();
            check($sformatf("ch%0d valid/err exclusive", g), {63'd0, valid[g] & ferr[g]}, 64'd0);
            check($sformatf("ch%0d event expected", g), {63'd0, qs > 0}, 64'd1);
            if (qs > 0) begin
              e = (g == 0) ? exp0.pop_front() : exp1.pop_front();
              check($sformatf("ch%0d frame_err", g), {63'd0, ferr[g]}, {63'd0, e.err});
              check($sformatf("ch%0d sample", g), {46'd0, samp[g]}, {46'd0, e.smp});
              if (e.t0 >= 0)
                check($sformatf("ch%0d latency", g), (edge_t - e.t0) / PER,
                      (g == 0) ? LAT0 : LAT1);
              if (e.gap > 0)
                check($sformatf("ch%0d period", g), (edge_t - last_evt[g]) / PER, e.gap);
            end
            last_evt[g] = edge_t;
          end
        end
      end
    join_none

    // Reset state
    wait_cyc(3);
    #1;
    check("reset cs_n", {63'd0, cs_n[0]}, 64'd1);
    check("reset sclk", {63'd0, sclk[0]}, 64'd1);
    check("reset sample", {46'd0, samp[0]}, 64'd0);
    check("reset valid/err", {62'd0, valid[0], ferr[0]}, 64'd0);
    check("reset busy", {63'd0, busy[0]}, 64'd0);
    rst = 1'b1;

    // Reset mid-SHIFT at cycle 60: aborts, no result ever published
    frames0.push_back(16'h0ABC);
    start_pulse(0, t0);
    wait_cyc(59);
    check("busy mid-frame", {63'd0, busy[0]}, 64'd1);
    #1 rst = 1'b0;
    #1;
    check("abort cs_n", {63'd0, cs_n[0]}, 64'd1);
    check("abort sclk", {63'd0, sclk[0]}, 64'd1);
    check("abort busy", {63'd0, busy[0]}, 64'd0);
    check("abort sample", {46'd0, samp[0]}, 64'd0);
    wait_cyc(2);
    #1 rst = 1'b1;
    wait_cyc(200);

    // Single conversion 0x0A5C
    frames0.push_back(16'h0A5C);
    start_pulse(0, t0);
    push_exp(0, 1'b0, 18'h00A5C, t0, 0);
    wait_cyc(150);
    check("cs_n fall edge", (fall_t[0] - t0) / PER, 64'd1);
    check("sclk rises per frame", rises_done[0], 64'd16);

    // Back-to-back 0x0123 then 0x0FFF
    frames0.push_back(16'h0123);
    frames0.push_back(16'h0FFF);
    start_hold(0, t0);
    push_exp(0, 1'b0, ext(12'h123), t0, 0);
    push_exp(0, 1'b0, ext(12'hFFF), -1, FULL0);
    wait_cyc(150);
    #1 ena[0] = 1'b0;
    wait_cyc(200);

    // Frame error after a good frame: sample held
    frames0.push_back(16'h0456);
    frames0.push_back(16'h8123);
    start_hold(0, t0);
    push_exp(0, 1'b0, ext(12'h456), t0, 0);
    push_exp(0, 1'b1, ext(12'h456), -1, FULL0);
    wait_cyc(150);
    #1 ena[0] = 1'b0;
    wait_cyc(200);

    // Requests during SHIFT and QUIET are ignored
    f0 = falls[0];
    frames0.push_back(16'h0321);
    start_pulse(0, t0);
    push_exp(0, 1'b0, ext(12'h321), t0, 0);
    wait_cyc(50);
    #1 ena[0] = 1'b1;
    @(posedge clk); #1 ena[0] = 1'b0;
    wait_cyc(85);
    #1 ena[0] = 1'b1;
    @(posedge clk); #1 ena[0] = 1'b0;
    wait_cyc(300);
    check("frames after ignored requests", falls[0] - f0, 64'd1);
    check("idle after ignored requests", {63'd0, busy[0]}, 64'd0);

    // CLK_DIV=1 boundary: 2-cycle sclk, valid at edge 34
    frames1.push_back(16'h0ABC);
    start_pulse(1, t0);
    push_exp(1, 1'b0, ext(12'hABC), t0, 0);
    wait_cyc(60);
    check("ch1 sclk period", rise_per[1], 2 * PER);
    check("ch1 sclk rises", rises_done[1], 64'd16);

    // Offset-binary examples (zero extension in the default build)
    frames0.push_back(16'h0800);
    frames0.push_back(16'h0FFF);
    frames0.push_back(16'h0000);
    start_hold(0, t0);
`ifdef ADC_OFFSET_BIN_EN
    push_exp(0, 1'b0, 18'h00000, t0, 0);
    push_exp(0, 1'b0, 18'h007FF, -1, FULL0);
    push_exp(0, 1'b0, 18'h3F800, -1, FULL0);
`else
    push_exp(0, 1'b0, 18'h00800, t0, 0);
    push_exp(0, 1'b0, 18'h00FFF, -1, FULL0);
    push_exp(0, 1'b0, 18'h00000, -1, FULL0);
`endif
    wait_cyc(294);
    #1 ena[0] = 1'b0;
    wait_cyc(250);

    check("ch0 expected events drained", exp0.size(), 64'd0);
    check("ch1 expected events drained", exp1.size(), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
